// File: rtl/alu_seq_ctrl_pkg.sv
// Shared definitions for the ALU issue/sequencing controller:
// opsel codes, flag bit positions, FSM encoding and op-class helpers.
package alu_seq_ctrl_pkg;

  // ALU opsel codes (5 bits). Codes 13..15 are unassigned; 16..31 are shifts.
  localparam logic [4:0] ALU_ADD     = 5'd0;
  localparam logic [4:0] ALU_SUB     = 5'd1;
  localparam logic [4:0] ALU_INC     = 5'd2;
  localparam logic [4:0] ALU_DEC     = 5'd3;
  localparam logic [4:0] ALU_AND     = 5'd4;
  localparam logic [4:0] ALU_OR      = 5'd5;
  localparam logic [4:0] ALU_XOR     = 5'd6;
  localparam logic [4:0] ALU_NOT     = 5'd7;
  localparam logic [4:0] ALU_NEG     = 5'd8;
  localparam logic [4:0] ALU_MUL     = 5'd9;
  localparam logic [4:0] ALU_DIV     = 5'd10;
  localparam logic [4:0] ALU_MOD     = 5'd11;
  localparam logic [4:0] ALU_SHORT_B = 5'd12;
  localparam logic [4:0] ALU_SHL     = 5'd16;
  localparam logic [4:0] ALU_SHR     = 5'd17;
  localparam logic [4:0] ALU_SAR     = 5'd18;
  localparam logic [4:0] ALU_ROL     = 5'd19;
  localparam logic [4:0] ALU_ROR     = 5'd20;

  // Bit positions inside the {ZF,NF,CF,OF} flag vector.
  localparam int FLAG_ZF = 3;
  localparam int FLAG_NF = 2;
  localparam int FLAG_CF = 1;
  localparam int FLAG_OF = 0;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Latency classes: single-cycle, multiplier, divider.
  typedef enum logic [1:0] {
    LAT_ONE = 2'd0,
    LAT_MUL = 2'd1,
    LAT_DIV = 2'd2
  } lat_class_e;

  // Which hold time an opsel needs at the ALU inputs.
  function automatic lat_class_e op_lat_class(input logic [4:0] op);
    lat_class_e cls;
    case (op)
      ALU_MUL:          cls = LAT_MUL;
      ALU_DIV, ALU_MOD: cls = LAT_DIV;
      default:          cls = LAT_ONE;
    endcase
    return cls;
  endfunction

  // Ops whose result commits all four ALU flags; everything else
  // (SHORT_B, shifts, unassigned codes) leaves the flags alone.
  function automatic logic op_writes_flags(input logic [4:0] op);
    logic wr;
    case (op)
      ALU_ADD, ALU_SUB, ALU_INC, ALU_DEC,
      ALU_AND, ALU_OR,  ALU_XOR, ALU_NOT,
      ALU_NEG, ALU_MUL, ALU_DIV, ALU_MOD: wr = 1'b1;
      default:                            wr = 1'b0;
    endcase
    return wr;
  endfunction

  // Divider-class ops (used by the divide-by-zero trap).
  function automatic logic op_is_div(input logic [4:0] op);
    return (op == ALU_DIV) || (op == ALU_MOD);
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Request/response handshake bundle between execute, the ALU sequencer
// and writeback. The sequencer takes the slave view; the producer/consumer
// side takes the master view.
interface alu_seq_ctrl_if #(
  parameter int WIDTH = 16
);

  logic             req_valid;
  logic             req_ready;
  logic [4:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [WIDTH-1:0] req_x;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_res;
  logic [WIDTH-1:0] rsp_extra;

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_x, rsp_ready,
    output req_ready, rsp_valid, rsp_res, rsp_extra
  );

  modport master (
    output req_valid, req_op, req_a, req_b, req_x, rsp_ready,
    input  req_ready, rsp_valid, rsp_res, rsp_extra
  );

endinterface

// File: rtl/alu_seq_lat.sv
// Combinational opsel decode: hold count minus one and flag-write enable.
module alu_seq_lat
  import alu_seq_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 4,
  parameter int CNT_W      = 2
) (
  input  logic [4:0]       opsel,
  output logic [CNT_W-1:0] lat_m1,
  output logic             writes_flags
);

  // Map the op's latency class onto its counter preload.
  always_comb begin
    lat_m1       = '0;
    writes_flags = op_writes_flags(opsel);
    case (op_lat_class(opsel))
      LAT_MUL: lat_m1 = CNT_W'(MUL_CYCLES - 1);
      LAT_DIV: lat_m1 = CNT_W'(DIV_CYCLES - 1);
      default: lat_m1 = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// ALU issue/sequencing controller: accepts one op, holds the ALU inputs for
// the op's latency, captures the result, owns the {ZF,NF,CF,OF} flags and
// hands the result to writeback.
// Optional build macro ALU_SEQ_DIV0_TRAP_EN: adds div0_trap and turns a
// DIV/MOD with srcB==0 into an immediate zero result without touching flags.
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  alu_seq_ctrl_if.slave    bus,
  output logic [3:0]       flags,
  input  logic             flag_wr,
  input  logic [3:0]       flag_wdata,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] alu_srcA,
  output logic [WIDTH-1:0] alu_srcB,
  output logic [WIDTH-1:0] alu_extra_X,
  output logic [4:0]       alu_opsel,
  output logic             alu_Cflag,
  output logic             alu_Oflag,
  input  logic [WIDTH-1:0] alu_res,
  input  logic [WIDTH-1:0] alu_extra_res,
  input  logic             alu_ready,
  input  logic [3:0]       alu_flag_next
`ifdef ALU_SEQ_DIV0_TRAP_EN
  ,
  output logic             div0_trap
`endif
);

  // Counter must hold max(MUL_CYCLES, DIV_CYCLES) - 1.
  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  state_e           state_q, state_d;
  logic             rdy_q, vld_q, busy_q;

  logic [4:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, x_q;
  logic             wf_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] res_q, extra_q;
  logic [3:0]       flags_q;

  logic [CNT_W-1:0] lat_m1;
  logic             writes_flags;

  logic             accept;
  logic             capture;
  logic             trap_take;

  alu_seq_lat #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_lat (
    .opsel        (bus.req_op),
    .lat_m1       (lat_m1),
    .writes_flags (writes_flags)
  );

  // Handshake qualifiers and next-state selection; flush overrides everything.
  always_comb begin
    accept    = (state_q == ST_IDLE) && bus.req_valid && !flush;
    capture   = (state_q == ST_EXEC) && (cnt_q == '0) && alu_ready && !flush;
`ifdef ALU_SEQ_DIV0_TRAP_EN
    trap_take = accept && op_is_div(bus.req_op) && (bus.req_b == '0);
`else
    trap_take = 1'b0;
`endif
    state_d   = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.req_valid) state_d = trap_take ? ST_DONE : ST_EXEC;
        ST_EXEC: if ((cnt_q == '0) && alu_ready) state_d = ST_DONE;
        ST_DONE: if (bus.rsp_ready) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State register plus registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d == ST_IDLE);
      vld_q   <= (state_d == ST_DONE);
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  // Operand latches: loaded once per accepted op, held through EXEC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      x_q  <= '0;
      wf_q <= 1'b0;
    end else if (accept) begin
      op_q <= bus.req_op;
      a_q  <= bus.req_a;
      b_q  <= bus.req_b;
      x_q  <= bus.req_x;
      wf_q <= writes_flags;
    end
  end

  // Hold counter: preloaded with L-1, counts down to zero, never wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= lat_m1;
    end else if ((state_q == ST_EXEC) && !flush && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Result registers: ALU capture, or forced zero on a divide-by-zero trap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_q   <= '0;
      extra_q <= '0;
    end else if (trap_take) begin
      res_q   <= '0;
      extra_q <= '0;
    end else if (capture) begin
      res_q   <= alu_res;
      extra_q <= alu_extra_res;
    end
  end

  // Architectural flags: a capture owns the cycle, otherwise flag_wr loads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags_q <= '0;
    end else if (capture) begin
      if (wf_q) flags_q <= alu_flag_next;
    end else if (flag_wr) begin
      flags_q <= flag_wdata;
    end
  end

`ifdef ALU_SEQ_DIV0_TRAP_EN
  logic trap_q;

  // Remember whether the op now in DONE was a trapped divide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trap_q <= 1'b0;
    end else if (accept) begin
      trap_q <= trap_take;
    end
  end

  assign div0_trap = trap_q && vld_q;
`endif

  assign bus.req_ready = rdy_q;
  assign bus.rsp_valid = vld_q;
  assign bus.rsp_res   = res_q;
  assign bus.rsp_extra = extra_q;
  assign busy          = busy_q;
  assign flags         = flags_q;
  assign alu_srcA      = a_q;
  assign alu_srcB      = b_q;
  assign alu_extra_X   = x_q;
  assign alu_opsel     = op_q;
  assign alu_Cflag     = flags_q[FLAG_CF];
  assign alu_Oflag     = flags_q[FLAG_OF];

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed testbench for alu_seq_ctrl with a small behavioural ALU model.
module tb_alu_seq_ctrl;
  import alu_seq_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  flags;
  logic        flag_wr;
  logic [3:0]  flag_wdata;
  logic        flush;
  logic        busy;
  logic [15:0] alu_srcA, alu_srcB, alu_extra_X;
  logic [4:0]  alu_opsel;
  logic        alu_Cflag, alu_Oflag;
  logic [15:0] alu_res, alu_extra_res;
  logic        alu_ready;
  logic [3:0]  alu_flag_next;
`ifdef ALU_SEQ_DIV0_TRAP_EN
  logic        div0_trap;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl_if #(.WIDTH(16)) bus ();

  alu_seq_ctrl #(
    .WIDTH      (16),
    .MUL_CYCLES (2),
    .DIV_CYCLES (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .flags         (flags),
    .flag_wr       (flag_wr),
    .flag_wdata    (flag_wdata),
    .flush         (flush),
    .busy          (busy),
    .alu_srcA      (alu_srcA),
    .alu_srcB      (alu_srcB),
    .alu_extra_X   (alu_extra_X),
    .alu_opsel     (alu_opsel),
    .alu_Cflag     (alu_Cflag),
    .alu_Oflag     (alu_Oflag),
    .alu_res       (alu_res),
    .alu_extra_res (alu_extra_res),
    .alu_ready     (alu_ready),
    .alu_flag_next (alu_flag_next)
`ifdef ALU_SEQ_DIV0_TRAP_EN
    ,
    .div0_trap     (div0_trap)
`endif
  );

  // Behavioural ALU: ADD, MUL, DIV/MOD, SHORT_B, XOR-ish fallback.
  logic [16:0] sum;
  logic [31:0] prod, dvd, quo, rem;
  always_comb begin
    sum           = '0;
    prod          = '0;
    quo           = '0;
    rem           = '0;
    dvd           = {alu_extra_X, alu_srcA};
    alu_res       = '0;
    alu_extra_res = '0;
    alu_flag_next = '0;
    case (alu_opsel)
      ALU_ADD: begin
        sum           = {1'b0, alu_srcA} + {1'b0, alu_srcB};
        alu_res       = sum[15:0];
        alu_flag_next = {sum[15:0] == 16'h0, sum[15], sum[16],
                         (alu_srcA[15] == alu_srcB[15]) && (sum[15] != alu_srcA[15])};
      end
      ALU_MUL: begin
        prod          = {16'h0, alu_srcA} * {16'h0, alu_srcB};
        alu_res       = prod[15:0];
        alu_extra_res = prod[31:16];
        alu_flag_next = {prod == 32'h0, prod[31], 2'b00};
      end
      ALU_DIV, ALU_MOD: begin
        if (alu_srcB == 16'h0) begin
          alu_res       = 16'hFFFF;
          alu_flag_next = 4'b0010;
        end else begin
          quo           = dvd / {16'h0, alu_srcB};
          rem           = dvd % {16'h0, alu_srcB};
          alu_res       = (alu_opsel == ALU_DIV) ? quo[15:0] : rem[15:0];
          alu_extra_res = quo[31:16];
          alu_flag_next = {alu_res == 16'h0, alu_res[15], 2'b00};
        end
      end
      ALU_SHORT_B: begin
        alu_res       = alu_srcB;
        alu_flag_next = 4'b0000;
      end
      default: begin
        alu_res       = alu_srcA ^ alu_srcB;
        alu_extra_res = alu_srcA;
        alu_flag_next = 4'b1010;
      end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for the acceptance edge, then scramble req_* so any
  // leak of the live bus into the ALU inputs shows up.
  task automatic issue(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] x);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_x     = x;
    tick();
    bus.req_valid = 1'b0;
    bus.req_op    = ALU_XOR;
    bus.req_a     = 16'hDEAD;
    bus.req_b     = 16'hBEEF;
    bus.req_x     = 16'hCAFE;
  endtask

  task automatic load_flags(input logic [3:0] f);
    flag_wr    = 1'b1;
    flag_wdata = f;
    tick();
    flag_wr    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b0;
    flag_wr       = 1'b0;
    flag_wdata    = 4'h0;
    flush         = 1'b0;
    alu_ready     = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = ALU_ADD;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_x     = '0;
    bus.rsp_ready = 1'b1;
    repeat (2) tick();

    // Reset state
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", flags, 4'h0);
    chk("rst_rsp_res", bus.rsp_res, 16'h0);
    chk("rst_oflag", alu_Oflag, 0);
    rst = 1'b1;
    tick();

    // ADD 0x7FFF + 1: result at cycle 2, NF and OF set
    issue(ALU_ADD, 16'h7FFF, 16'h0001, 16'h0000);
    chk("add_c1_valid", bus.rsp_valid, 0);
    chk("add_c1_busy", busy, 1);
    chk("add_c1_srcA_latched", alu_srcA, 16'h7FFF);
    tick();
    chk("add_c2_valid", bus.rsp_valid, 1);
    chk("add_res", bus.rsp_res, 16'h8000);
    chk("add_flags", flags, 4'b0101);
    tick();
    chk("add_back_idle", bus.req_ready, 1);

    // MUL 0x100 * 0x100: result at cycle 3
    issue(ALU_MUL, 16'h0100, 16'h0100, 16'h0000);
    chk("mul_c1_valid", bus.rsp_valid, 0);
    tick();
    chk("mul_c2_valid", bus.rsp_valid, 0);
    tick();
    chk("mul_c3_valid", bus.rsp_valid, 1);
    chk("mul_res", bus.rsp_res, 16'h0000);
    chk("mul_extra", bus.rsp_extra, 16'h0001);
    chk("mul_flags", flags, 4'b0000);
    tick();

    // flag_wr, then SHORT_B must leave flags alone; writeback stalls 5 cycles
    load_flags(4'b1111);
    chk("fwr_flags", flags, 4'b1111);
    chk("fwr_cflag", alu_Cflag, 1);
    chk("fwr_oflag", alu_Oflag, 1);
    bus.rsp_ready = 1'b0;
    issue(ALU_SHORT_B, 16'h0000, 16'h1234, 16'h0000);
    tick();
    chk("sb_valid", bus.rsp_valid, 1);
    chk("sb_res", bus.rsp_res, 16'h1234);
    chk("sb_flags", flags, 4'b1111);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", bus.rsp_valid, 1);
      chk("stall_res", bus.rsp_res, 16'h1234);
      chk("stall_req_ready", bus.req_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    chk("stall_release_idle", bus.req_ready, 1);
    chk("stall_release_valid", bus.rsp_valid, 0);

    // ALU not ready at the capture point: retry until it is
    alu_ready = 1'b0;
    issue(ALU_ADD, 16'h0001, 16'h0001, 16'h0000);
    tick();
    chk("retry_busy", busy, 1);
    chk("retry_valid", bus.rsp_valid, 0);
    alu_ready = 1'b1;
    tick();
    chk("retry_valid_late", bus.rsp_valid, 1);
    chk("retry_res", bus.rsp_res, 16'h0002);
    chk("retry_flags", flags, 4'b0000);
    tick();

    // DIV flushed in its second EXEC cycle
    load_flags(4'b1001);
    issue(ALU_DIV, 16'h0064, 16'h0007, 16'h0000);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_req_ready", bus.req_ready, 1);
    chk("flush_valid", bus.rsp_valid, 0);
    chk("flush_flags", flags, 4'b1001);
    tick();
    chk("flush_valid_later", bus.rsp_valid, 0);

    // flush together with a request in IDLE: not accepted
    bus.req_valid = 1'b1;
    bus.req_op    = ALU_ADD;
    flush         = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    flush         = 1'b0;
    chk("flush_req_rejected", busy, 0);

    // Normal ADD after the flush
    issue(ALU_ADD, 16'h0002, 16'h0003, 16'h0000);
    tick();
    chk("post_flush_valid", bus.rsp_valid, 1);
    chk("post_flush_res", bus.rsp_res, 16'h0005);
    chk("post_flush_flags", flags, 4'b0000);
    tick();

    // Divide by zero
    load_flags(4'b0100);
    issue(ALU_DIV, 16'h0064, 16'h0000, 16'h0000);
`ifdef ALU_SEQ_DIV0_TRAP_EN
    chk("div0_valid_c1", bus.rsp_valid, 1);
    chk("div0_trap_c1", div0_trap, 1);
    chk("div0_res", bus.rsp_res, 16'h0000);
    chk("div0_extra", bus.rsp_extra, 16'h0000);
    chk("div0_flags", flags, 4'b0100);
    tick();
    chk("div0_trap_clear", div0_trap, 0);
    chk("div0_valid_clear", bus.rsp_valid, 0);
`else
    chk("div0_valid_c1", bus.rsp_valid, 0);
    repeat (3) tick();
    chk("div0_valid_c4", bus.rsp_valid, 0);
    tick();
    chk("div0_valid_c5", bus.rsp_valid, 1);
    chk("div0_res", bus.rsp_res, 16'hFFFF);
    chk("div0_cflag", alu_Cflag, 1);
    chk("div0_flags", flags, 4'b0010);
    tick();
`endif

    // Asynchronous reset in the middle of a DIV
    load_flags(4'b1111);
    issue(ALU_DIV, 16'h0064, 16'h0007, 16'h0000);
    tick();
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_req_ready", bus.req_ready, 1);
    chk("arst_valid", bus.rsp_valid, 0);
    chk("arst_flags", flags, 4'h0);
    chk("arst_srcA", alu_srcA, 16'h0);
    chk("arst_srcB", alu_srcB, 16'h0);
    chk("arst_rsp_res", bus.rsp_res, 16'h0);
    #1 rst = 1'b1;
    tick();

    issue(ALU_ADD, 16'h0003, 16'h0004, 16'h0000);
    tick();
    chk("arst_after_add_res", bus.rsp_res, 16'h0007);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Issue/sequencing controller in front of the 16-bit ALU.
- Accepts one operation at a time from the execute stage over a valid/ready handshake and latches the operands.
- Drives the ALU and holds the ALU inputs stable for the op's multicycle latency, since MUL, DIV and MOD are slow combinational paths.
- Captures the result, owns the architectural {ZF,NF,CF,OF} flag register, and presents the result to writeback over a second valid/ready handshake.

Parameters:
- WIDTH, 16, datapath width. Fixed at 16 for the current ALU.
- MUL_CYCLES, 2, cycles the ALU inputs are held for ALU_MUL (min 1).
- DIV_CYCLES, 4, cycles the ALU inputs are held for ALU_DIV and ALU_MOD (min 1).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when high together with req_valid
- req_op  in  5  ALU opsel code (shared opsel defines)
- req_a / req_b / req_x  in  16 each  srcA / srcB / extra_X operands
- rsp_valid  out  1  result valid
- rsp_ready  in  1  writeback accepts the result
- rsp_res / rsp_extra  out  16 each  result and extra result (high half for MUL, DIV)
- flags  out  4  architectural flags {ZF,NF,CF,OF}
- flag_wr / flag_wdata  in  1 / 4  direct flag load (POPF-style)
- flush  in  1  synchronous abort of the in-flight op
- busy  out  1  high in any state other than IDLE
- alu_srcA / alu_srcB / alu_extra_X  out  16 each  to ALU
- alu_opsel  out  5  to ALU
- alu_Cflag / alu_Oflag  out  1 each  equal to flags[1] / flags[0]
- alu_res / alu_extra_res  in  16 each  from ALU
- alu_ready  in  1  from ALU
- alu_flag_next  in  4  from ALU

Behaviour:
- Reset (rst=0, async): state=IDLE, flags=0, rsp_res=0, rsp_extra=0, rsp_valid=0, all operand latches=0, counter=0. Outputs are registered; req_ready=1 after reset.
- FSM states: IDLE, EXEC, DONE.
- IDLE: req_ready=1.
  - req_valid & ~flush: latch op and operands.
  - Load cnt with L-1, where L=MUL_CYCLES for MUL, DIV_CYCLES for DIV/MOD, otherwise 1.
  - Go to EXEC.
- EXEC: ALU inputs driven only from the latches (never directly from req_*).
  - cnt!=0: decrement cnt.
  - cnt==0 & alu_ready: capture alu_res and alu_extra_res into rsp_*, update flags, go to DONE.
  - cnt==0 & ~alu_ready: stay in EXEC and retry each cycle.
- DONE: rsp_valid=1.
  - rsp_* stay stable until rsp_ready.
  - On rsp_ready: go to IDLE.
  - No new request is accepted in DONE.
- Latency: acceptance edge at cycle 0 gives rsp_valid at cycle L+1. Throughput is one op per L+2 cycles with rsp_ready held high.
- Flag update mask:
  - ADD/SUB/INC/DEC/AND/OR/XOR/NOT/NEG/MUL/DIV/MOD: flags <= alu_flag_next (all 4 bits).
  - ALU_SHORT_B, all shift codes (16..31) and undefined codes: flags unchanged.
- Flag priority: capture > flag_wr. flag_wr is honoured in any state when no capture occurs in the same cycle.
- flush:
  - Forces IDLE from any state next cycle.
  - No flag update and no rsp_valid for the aborted op; rsp_valid drops next cycle.
  - flush together with req_valid in IDLE: request is not accepted.
- Undefined opsel: executes with L=1 and returns whatever the ALU produces. Flags unchanged.
- Counter is wide enough for max(MUL_CYCLES,DIV_CYCLES)-1 and never wraps.

Optional Feature:
- Macro ALU_SEQ_DIV0_TRAP_EN.
- Defined:
  - Add output div0_trap (1 bit).
  - DIV/MOD with latched srcB==0 skips EXEC: IDLE -> DONE directly.
  - rsp_res=0, rsp_extra=0, flags unchanged.
  - div0_trap=1 for exactly the cycles rsp_valid is high for that op.
- Not defined: no port. Divide by zero executes normally and CF comes from the ALU.

Decomposition:
- Shared package/include holds:
  - existing opsel codes;
  - flag bit indices ZF=3, NF=2, CF=1, OF=0;
  - FSM state encodings;
  - op-class helper constants (flag-writing set, latency class).
- One natural sub-module: alu_seq_lat, a combinational map opsel -> {L-1, writes_flags}.

Test Plan:
- ADD a=0x7FFF b=0x0001 -> rsp_res=0x8000 at cycle 2, flags=4'b0101.
- MUL a=0x0100 b=0x0100 (MUL_CYCLES=2) -> rsp_valid at cycle 3, rsp_res=0x0000, rsp_extra=0x0001, flags=4'b0000.
- flag_wr 4'b1111, then SHORT_B b=0x1234 -> rsp_res=0x1234, flags stay 4'b1111. Then rsp_ready=0 for 5 cycles -> rsp stable, req_ready=0 throughout.
- DIV {x,a}=0x00000064 b=0x0007, flush asserted in the 2nd EXEC cycle -> IDLE next cycle, no rsp_valid, flags unchanged, next ADD accepted normally.
- rst pulled low mid-EXEC of a DIV -> all outputs return to reset values immediately, flags=0.
- DIV b=0x0000 -> with ALU_SEQ_DIV0_TRAP_EN: rsp_valid at cycle 1, div0_trap=1, flags unchanged. Without the macro: rsp_valid at cycle 5 and CF=1.
